// File: rtl/gpu_command_decoder_if.sv
// Command and instruction buses of the GPU command decoder.
// The master modport is the command source and rasteriser side.
// The slave modport is the decoder itself.
interface gpu_command_decoder_if #(
   parameter int WIDTH_BITS   = 10,
   parameter int HEIGHT_BITS  = 9,
   parameter int CHANNEL_BITS = 8,
   parameter int PARAM_BITS   = 28,
   parameter int FIFO_DEPTH   = 4
);
   logic                            cmd_valid_i;
   logic                            cmd_ready_o;
   logic [3:0]                      opcode_i;
   logic [PARAM_BITS-1:0]           parameters_i;
   logic                            instr_valid_o;
   logic                            instr_ready_i;
   logic [3:0]                      opcode_o;
   logic [WIDTH_BITS-1:0]           x1_o;
   logic [WIDTH_BITS-1:0]           x2_o;
   logic [WIDTH_BITS-1:0]           rad_o;
   logic [HEIGHT_BITS-1:0]          y1_o;
   logic [HEIGHT_BITS-1:0]          y2_o;
   logic [2:0]                      oct_o;
   logic [CHANNEL_BITS-1:0]         r_o;
   logic [CHANNEL_BITS-1:0]         g_o;
   logic [CHANNEL_BITS-1:0]         b_o;
   logic                            illegal_o;
   logic [$clog2(FIFO_DEPTH):0]     fifo_count_o;

   modport master (
      output cmd_valid_i, opcode_i, parameters_i, instr_ready_i,
      input  cmd_ready_o, instr_valid_o, opcode_o, x1_o, x2_o, rad_o,
             y1_o, y2_o, oct_o, r_o, g_o, b_o, illegal_o, fifo_count_o
   );

   modport slave (
      input  cmd_valid_i, opcode_i, parameters_i, instr_ready_i,
      output cmd_ready_o, instr_valid_o, opcode_o, x1_o, x2_o, rad_o,
             y1_o, y2_o, oct_o, r_o, g_o, b_o, illegal_o, fifo_count_o
   );
endinterface

// File: rtl/gpu_command_decoder.sv
// GPU command decoder: shadow registers for vertices, radius, octant and
// colour, plus a first-word-fall-through instruction FIFO for the rasteriser.
// Optional macro GPU_DECODER_CLIP_EN clamps set_xy coordinates to the screen.
module gpu_command_decoder #(
   parameter int WIDTH_BITS   = 10,
   parameter int HEIGHT_BITS  = 9,
   parameter int CHANNEL_BITS = 8,
   parameter int PARAM_BITS   = 28,
   parameter int FIFO_DEPTH   = 4,
   parameter int SCREEN_W     = 640,
   parameter int SCREEN_H     = 480
) (
   input logic clk,
   input logic rst,
   gpu_command_decoder_if.slave bus
);
   localparam int PTR_BITS = $clog2(FIFO_DEPTH);
   localparam int CNT_BITS = PTR_BITS + 1;
   localparam int C        = CHANNEL_BITS;

`ifdef GPU_DECODER_CLIP_EN
   localparam bit CLIP_EN = 1'b1;
`else
   localparam bit CLIP_EN = 1'b0;
`endif

   localparam logic [WIDTH_BITS-1:0]  X_MAX = WIDTH_BITS'(SCREEN_W - 1);
   localparam logic [HEIGHT_BITS-1:0] Y_MAX = HEIGHT_BITS'(SCREEN_H - 1);

   typedef struct packed {
      logic [3:0]              opcode;
      logic [WIDTH_BITS-1:0]   x1;
      logic [HEIGHT_BITS-1:0]  y1;
      logic [WIDTH_BITS-1:0]   x2;
      logic [HEIGHT_BITS-1:0]  y2;
      logic [WIDTH_BITS-1:0]   rad;
      logic [2:0]              oct;
      logic [C-1:0]            r;
      logic [C-1:0]            g;
      logic [C-1:0]            b;
   } entry_t;

   logic [WIDTH_BITS-1:0]  x1_q, x2_q, rad_q;
   logic [HEIGHT_BITS-1:0] y1_q, y2_q;
   logic [2:0]             oct_q;
   logic [C-1:0]           r_q, g_q, b_q;
   logic                   illegal_q;

   entry_t                 fifo_mem [FIFO_DEPTH];
   logic [PTR_BITS-1:0]    wr_ptr, rd_ptr;
   logic [CNT_BITS-1:0]    count;

   logic                   accept, push, pop;
   logic                   is_soft, is_draw, is_fill, is_illegal;
   logic [WIDTH_BITS-1:0]  p_x, clip_x;
   logic [HEIGHT_BITS-1:0] p_y, clip_y;
   logic [C-1:0]           p_r, p_g, p_b;
   logic [2:0]             p_oct;
   entry_t                 new_entry, head;
   logic                   unused_param_bits;

   assign bus.cmd_ready_o   = (count != CNT_BITS'(FIFO_DEPTH));
   assign bus.instr_valid_o = (count != '0);
   assign accept            = bus.cmd_valid_i && bus.cmd_ready_o;

   assign is_soft    = (bus.opcode_i == 4'h0);
   assign is_draw    = (bus.opcode_i >= 4'h4) && (bus.opcode_i <= 4'h7);
   assign is_fill    = (bus.opcode_i == 4'h8);
   assign is_illegal = (bus.opcode_i >= 4'h9);

   assign push = accept && (is_draw || is_fill);
   assign pop  = bus.instr_ready_i && bus.instr_valid_o;

   assign p_x   = bus.parameters_i[WIDTH_BITS-1:0];
   assign p_y   = bus.parameters_i[WIDTH_BITS+HEIGHT_BITS-1:WIDTH_BITS];
   assign p_b   = bus.parameters_i[C-1:0];
   assign p_g   = bus.parameters_i[2*C-1:C];
   assign p_r   = bus.parameters_i[3*C-1:2*C];
   assign p_oct = bus.parameters_i[3*C+2:3*C];

   assign clip_x = (CLIP_EN && (p_x > X_MAX)) ? X_MAX : p_x;
   assign clip_y = (CLIP_EN && (p_y > Y_MAX)) ? Y_MAX : p_y;

   assign unused_param_bits = ^bus.parameters_i;

   // Build the FIFO entry: current shadow state, overridden by a draw's new colour/octant
   always_comb begin
      new_entry        = '0;
      new_entry.opcode = bus.opcode_i;
      new_entry.x1     = x1_q;
      new_entry.y1     = y1_q;
      new_entry.x2     = x2_q;
      new_entry.y2     = y2_q;
      new_entry.rad    = rad_q;
      new_entry.oct    = oct_q;
      new_entry.r      = r_q;
      new_entry.g      = g_q;
      new_entry.b      = b_q;
      if (is_draw) begin
         new_entry.r = p_r;
         new_entry.g = p_g;
         new_entry.b = p_b;
         if (bus.opcode_i == 4'h7) begin
            new_entry.oct = p_oct;
         end
      end
   end

   // Shadow registers and the one-cycle illegal-opcode pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x1_q      <= '0;
         y1_q      <= '0;
         x2_q      <= '0;
         y2_q      <= '0;
         rad_q     <= '0;
         oct_q     <= '0;
         r_q       <= '0;
         g_q       <= '0;
         b_q       <= '0;
         illegal_q <= 1'b0;
      end else begin
         illegal_q <= accept && is_illegal;
         if (accept) begin
            case (bus.opcode_i)
               4'h0: begin
                  x1_q  <= '0;
                  y1_q  <= '0;
                  x2_q  <= '0;
                  y2_q  <= '0;
                  rad_q <= '0;
                  oct_q <= '0;
                  r_q   <= '0;
                  g_q   <= '0;
                  b_q   <= '0;
               end
               4'h1: begin
                  x1_q <= clip_x;
                  y1_q <= clip_y;
               end
               4'h2: begin
                  x2_q <= clip_x;
                  y2_q <= clip_y;
               end
               4'h3: rad_q <= p_x;
               4'h4, 4'h5, 4'h6: begin
                  r_q <= p_r;
                  g_q <= p_g;
                  b_q <= p_b;
               end
               4'h7: begin
                  r_q   <= p_r;
                  g_q   <= p_g;
                  b_q   <= p_b;
                  oct_q <= p_oct;
               end
               default: ;
            endcase
         end
      end
   end

   // FIFO pointers and occupancy; a soft reset flushes and discards any same-cycle pop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (accept && is_soft) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_BITS'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_BITS'(1);
         end
         if (push && !pop) begin
            count <= count + CNT_BITS'(1);
         end else if (pop && !push) begin
            count <= count - CNT_BITS'(1);
         end
      end
   end

   // FIFO storage; contents only matter once the count marks them valid
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= new_entry;
      end
   end

   assign head = bus.instr_valid_o ? fifo_mem[rd_ptr] : '0;

   assign bus.opcode_o     = head.opcode;
   assign bus.x1_o         = head.x1;
   assign bus.y1_o         = head.y1;
   assign bus.x2_o         = head.x2;
   assign bus.y2_o         = head.y2;
   assign bus.rad_o        = head.rad;
   assign bus.oct_o        = head.oct;
   assign bus.r_o          = head.r;
   assign bus.g_o          = head.g;
   assign bus.b_o          = head.b;
   assign bus.illegal_o    = illegal_q;
   assign bus.fifo_count_o = count;
endmodule

// File: tb/tb_gpu_command_decoder.sv
// Directed self-checking bench for gpu_command_decoder.
// Define GPU_DECODER_CLIP_EN for both bench and RTL to exercise clipping.
module tb_gpu_command_decoder;
   localparam int W = 10;
   localparam int H = 9;
   localparam int C = 8;
   localparam int P = 28;
   localparam int D = 4;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   gpu_command_decoder_if #(
      .WIDTH_BITS(W), .HEIGHT_BITS(H), .CHANNEL_BITS(C),
      .PARAM_BITS(P), .FIFO_DEPTH(D)
   ) bus ();

   gpu_command_decoder #(
      .WIDTH_BITS(W), .HEIGHT_BITS(H), .CHANNEL_BITS(C),
      .PARAM_BITS(P), .FIFO_DEPTH(D), .SCREEN_W(640), .SCREEN_H(480)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] op, input logic [P-1:0] p);
      bus.cmd_valid_i  = 1'b1;
      bus.opcode_i     = op;
      bus.parameters_i = p;
      nextCycle();
      bus.cmd_valid_i  = 1'b0;
      bus.opcode_i     = 4'h0;
      bus.parameters_i = '0;
   endtask

   task automatic checkHead(input string tag, input int op, input int x1, input int y1,
                            input int x2, input int y2, input int rad, input int oct,
                            input int r, input int g, input int b);
      checkOutput({tag, ".valid"}, 32'(bus.instr_valid_o), 1);
      checkOutput({tag, ".op"},    32'(bus.opcode_o), op);
      checkOutput({tag, ".x1"},    32'(bus.x1_o), x1);
      checkOutput({tag, ".y1"},    32'(bus.y1_o), y1);
      checkOutput({tag, ".x2"},    32'(bus.x2_o), x2);
      checkOutput({tag, ".y2"},    32'(bus.y2_o), y2);
      checkOutput({tag, ".rad"},   32'(bus.rad_o), rad);
      checkOutput({tag, ".oct"},   32'(bus.oct_o), oct);
      checkOutput({tag, ".r"},     32'(bus.r_o), r);
      checkOutput({tag, ".g"},     32'(bus.g_o), g);
      checkOutput({tag, ".b"},     32'(bus.b_o), b);
   endtask

   task automatic popOne();
      bus.instr_ready_i = 1'b1;
      nextCycle();
      bus.instr_ready_i = 1'b0;
   endtask

   initial begin
      rst              = 1'b1;
      bus.cmd_valid_i  = 1'b0;
      bus.opcode_i     = 4'h0;
      bus.parameters_i = '0;
      bus.instr_ready_i = 1'b0;

      // reset state
      #3;
      checkOutput("rst.valid",   32'(bus.instr_valid_o), 0);
      checkOutput("rst.count",   32'(bus.fifo_count_o), 0);
      checkOutput("rst.illegal", 32'(bus.illegal_o), 0);
      checkOutput("rst.op",      32'(bus.opcode_o), 0);
      checkOutput("rst.x1",      32'(bus.x1_o), 0);
      #9;
      rst = 1'b0;
      nextCycle();
      checkOutput("rst.ready", 32'(bus.cmd_ready_o), 1);

      // set vertices then draw a line
      applyStimulus(4'h1, P'((50 << 10) | 100));
      applyStimulus(4'h2, P'((150 << 10) | 200));
      checkOutput("set.novalid", 32'(bus.instr_valid_o), 0);
      checkOutput("set.count",   32'(bus.fifo_count_o), 0);
      applyStimulus(4'h4, 28'h0FF8040);
      checkOutput("line.count", 32'(bus.fifo_count_o), 1);
      checkHead("line", 4, 100, 50, 200, 150, 0, 0, 'hFF, 'h80, 'h40);
      popOne();
      checkOutput("line.popcount", 32'(bus.fifo_count_o), 0);
      checkOutput("line.popvalid", 32'(bus.instr_valid_o), 0);

      // arc sets the octant, a following circle carries it
      applyStimulus(4'h7, 28'h3123456);
      applyStimulus(4'h6, 28'h7AABBCC);
      checkOutput("arc.count", 32'(bus.fifo_count_o), 2);
      checkHead("arc", 7, 100, 50, 200, 150, 0, 3, 'h12, 'h34, 'h56);
      popOne();
      checkHead("circle", 6, 100, 50, 200, 150, 0, 3, 'hAA, 'hBB, 'hCC);
      popOne();
      checkOutput("circle.count", 32'(bus.fifo_count_o), 0);

      // backpressure: fill the FIFO, hold the fifth command, then drain
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(4'h5, P'(i << 16));
      end
      checkOutput("full.count", 32'(bus.fifo_count_o), 4);
      checkOutput("full.ready", 32'(bus.cmd_ready_o), 0);
      bus.cmd_valid_i  = 1'b1;
      bus.opcode_i     = 4'h5;
      bus.parameters_i = P'(5 << 16);
      nextCycle();
      checkOutput("held.count", 32'(bus.fifo_count_o), 4);
      checkOutput("held.r",     32'(bus.r_o), 1);
      bus.instr_ready_i = 1'b1;
      nextCycle();
      checkOutput("pop1.count", 32'(bus.fifo_count_o), 3);
      checkOutput("pop1.ready", 32'(bus.cmd_ready_o), 1);
      checkOutput("pop1.r",     32'(bus.r_o), 2);
      nextCycle();
      bus.cmd_valid_i = 1'b0;
      checkOutput("pushpop.count", 32'(bus.fifo_count_o), 3);
      checkOutput("pushpop.r",     32'(bus.r_o), 3);
      nextCycle();
      checkOutput("pop3.r", 32'(bus.r_o), 4);
      nextCycle();
      checkOutput("pop4.r",  32'(bus.r_o), 5);
      checkOutput("pop4.op", 32'(bus.opcode_o), 5);
      nextCycle();
      bus.instr_ready_i = 1'b0;
      checkOutput("drain.count", 32'(bus.fifo_count_o), 0);
      checkOutput("drain.valid", 32'(bus.instr_valid_o), 0);

      // radius, illegal opcode, then a fill shows shadow state untouched
      applyStimulus(4'h3, 28'h0012345);
      applyStimulus(4'hA, 28'hFFFFFFF);
      checkOutput("illegal.pulse", 32'(bus.illegal_o), 1);
      checkOutput("illegal.count", 32'(bus.fifo_count_o), 0);
      nextCycle();
      checkOutput("illegal.clear", 32'(bus.illegal_o), 0);
      applyStimulus(4'h8, '0);
      checkHead("fill", 8, 100, 50, 200, 150, 'h345, 3, 5, 0, 0);
      popOne();

      // soft reset flushes queued draws and clears the shadow state
      for (int i = 0; i < 3; i++) begin
         applyStimulus(4'h4, 28'h0010203);
      end
      checkOutput("soft.pre", 32'(bus.fifo_count_o), 3);
      bus.instr_ready_i = 1'b1;
      applyStimulus(4'h0, '0);
      bus.instr_ready_i = 1'b0;
      checkOutput("soft.count", 32'(bus.fifo_count_o), 0);
      checkOutput("soft.valid", 32'(bus.instr_valid_o), 0);
      applyStimulus(4'h8, '0);
      checkHead("softfill", 8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      popOne();

      // clipping of set_xy coordinates
      applyStimulus(4'h1, P'((511 << 10) | 1000));
      applyStimulus(4'h8, '0);
`ifdef GPU_DECODER_CLIP_EN
      checkOutput("clip.x1", 32'(bus.x1_o), 639);
      checkOutput("clip.y1", 32'(bus.y1_o), 479);
`else
      checkOutput("clip.x1", 32'(bus.x1_o), 1000);
      checkOutput("clip.y1", 32'(bus.y1_o), 511);
`endif
      popOne();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
